// File: rtl/task_stream_rx.sv
// Task stream receiver: parses an application descriptor flit stream into task memory writes.
// Optional zero-fill of each task's BSS region is enabled by defining TASK_RX_BSS_CLEAR_EN.
module task_stream_rx #(
  parameter int FLIT_SIZE = 32,
  parameter int MAX_TASKS = 16,
  parameter int ADDR_W    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  input  logic [FLIT_SIZE-1:0] data_i,
  input  logic                 mem_ready_i,
  output logic                 credit_o,
  output logic [31:0]          app_hash_o,
  output logic [15:0]          task_cnt_o,
  output logic                 map_we_o,
  output logic [31:0]          map_o,
  output logic [31:0]          ttt_o,
  output logic                 graph_we_o,
  output logic [31:0]          graph_o,
  output logic                 mem_we_o,
  output logic [15:0]          mem_task_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [31:0]          mem_data_o,
  output logic [31:0]          entry_o,
  output logic                 task_done_o,
  output logic                 app_done_o,
  output logic                 err_o
);

  typedef enum logic [3:0] {
    S_DESCR, S_HASH, S_CNT, S_MAP, S_TTT, S_GRAPH,
    S_TEXT, S_DATA, S_BSS, S_ENTRY, S_BINARY,
    S_BSS_CLR, S_TASK_END, S_APP_END, S_ERROR
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         descr_q, descr_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [31:0]         hash_q, hash_d;
  logic [15:0]         tcnt_q, tcnt_d;
  logic [31:0]         map_q, map_d;
  logic [31:0]         ttt_q, ttt_d;
  logic                map_we_q, map_we_d;
  logic [31:0]         graph_q, graph_d;
  logic                graph_we_q, graph_we_d;
  logic [31:0]         text_q, text_d;
  logic [31:0]         dsz_q, dsz_d;
  logic [31:0]         bss_q, bss_d;
  logic [31:0]         entry_q, entry_d;
  logic [15:0]         tidx_q, tidx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         words_q, words_d;
  logic                tdone_q, tdone_d;
  logic                adone_q, adone_d;
  logic                err_q, err_d;

  logic [31:0] flit;
  logic        credit;
  logic        xfer;
  logic [32:0] bin_bytes;
  logic [32:0] bin_words;
  logic [32:0] span;
  logic [32:0] limit;
  logic        size_bad;

  assign flit = data_i[31:0];

  always_comb begin
    credit = 1'b1;
    unique case (1'b1)
      state_q == S_BINARY:   credit = mem_ready_i;
      state_q == S_BSS_CLR,
      state_q == S_TASK_END,
      state_q == S_APP_END:  credit = 1'b0;
      default:               credit = 1'b1;
    endcase
  end

  assign xfer = rx_i & credit;

  // Sizes are summed in 33 bits so a huge TEXT+DATA cannot wrap into range
  assign bin_bytes = {1'b0, text_q} + {1'b0, dsz_q};
  assign bin_words = bin_bytes >> 2;
  assign limit     = 33'd1 << ADDR_W;
`ifdef TASK_RX_BSS_CLEAR_EN
  logic [32:0] bss_words;
  assign bss_words = ({1'b0, bss_q} + 33'd3) >> 2;
  assign span      = bin_words + bss_words;
`else
  assign span      = bin_words;
`endif
  assign size_bad = (bin_bytes == 33'd0) ||
                    (bin_bytes[1:0] != 2'b00) ||
                    (span > limit);

  always_comb begin
    state_d    = state_q;
    descr_d    = descr_q;
    cnt_d      = cnt_q;
    hash_d     = hash_q;
    tcnt_d     = tcnt_q;
    map_d      = map_q;
    ttt_d      = ttt_q;
    graph_d    = graph_q;
    text_d     = text_q;
    dsz_d      = dsz_q;
    bss_d      = bss_q;
    entry_d    = entry_q;
    tidx_d     = tidx_q;
    addr_d     = addr_q;
    words_d    = words_q;
    map_we_d   = 1'b0;
    graph_we_d = 1'b0;
    tdone_d    = 1'b0;
    adone_d    = 1'b0;
    unique case (state_q)
      S_DESCR: if (xfer) begin
        descr_d = flit;
        state_d = S_HASH;
      end
      S_HASH: if (xfer) begin
        hash_d  = flit;
        state_d = S_CNT;
      end
      S_CNT: if (xfer) begin
        if (flit == 32'd0 || flit > 32'(MAX_TASKS)) begin
          state_d = S_ERROR;
        end else begin
          tcnt_d  = flit[15:0];
          cnt_d   = 32'd0;
          state_d = S_MAP;
        end
      end
      S_MAP: if (xfer) begin
        map_d   = flit;
        state_d = S_TTT;
      end
      S_TTT: if (xfer) begin
        ttt_d    = flit;
        map_we_d = 1'b1;
        cnt_d    = cnt_q + 32'd1;
        if (cnt_q + 32'd1 == {16'd0, tcnt_q}) begin
          cnt_d   = 32'd0;
          state_d = (descr_q == 32'd0) ? S_TEXT : S_GRAPH;
        end else begin
          state_d = S_MAP;
        end
      end
      S_GRAPH: if (xfer) begin
        graph_d    = flit;
        graph_we_d = 1'b1;
        cnt_d      = cnt_q + 32'd1;
        if (cnt_q + 32'd1 == descr_q) state_d = S_TEXT;
      end
      S_TEXT: if (xfer) begin
        text_d  = flit;
        state_d = S_DATA;
      end
      S_DATA: if (xfer) begin
        dsz_d   = flit;
        state_d = S_BSS;
      end
      S_BSS: if (xfer) begin
        bss_d   = flit;
        state_d = S_ENTRY;
      end
      S_ENTRY: if (xfer) begin
        entry_d = flit;
        addr_d  = '0;
        words_d = bin_words[31:0];
        state_d = size_bad ? S_ERROR : S_BINARY;
      end
      S_BINARY: if (xfer) begin
        addr_d  = addr_q + 1'b1;
        words_d = words_q - 32'd1;
        if (words_q == 32'd1) begin
          state_d = S_TASK_END;
`ifdef TASK_RX_BSS_CLEAR_EN
          if (bss_q != 32'd0) begin
            cnt_d   = bss_words[31:0];
            state_d = S_BSS_CLR;
          end
`endif
        end
      end
      S_BSS_CLR: if (mem_ready_i) begin
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_q - 32'd1;
        if (cnt_q == 32'd1) state_d = S_TASK_END;
      end
      S_TASK_END: begin
        tdone_d = 1'b1;
        tidx_d  = tidx_q + 16'd1;
        state_d = (tidx_q + 16'd1 == tcnt_q) ? S_APP_END : S_TEXT;
      end
      S_APP_END: begin
        adone_d = 1'b1;
        tidx_d  = 16'd0;
        state_d = S_DESCR;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
    err_d = err_q | (state_d == S_ERROR);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_DESCR;
      descr_q    <= '0;
      cnt_q      <= '0;
      hash_q     <= '0;
      tcnt_q     <= '0;
      map_q      <= '0;
      ttt_q      <= '0;
      map_we_q   <= 1'b0;
      graph_q    <= '0;
      graph_we_q <= 1'b0;
      text_q     <= '0;
      dsz_q      <= '0;
      bss_q      <= '0;
      entry_q    <= '0;
      tidx_q     <= '0;
      addr_q     <= '0;
      words_q    <= '0;
      tdone_q    <= 1'b0;
      adone_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      descr_q    <= descr_d;
      cnt_q      <= cnt_d;
      hash_q     <= hash_d;
      tcnt_q     <= tcnt_d;
      map_q      <= map_d;
      ttt_q      <= ttt_d;
      map_we_q   <= map_we_d;
      graph_q    <= graph_d;
      graph_we_q <= graph_we_d;
      text_q     <= text_d;
      dsz_q      <= dsz_d;
      bss_q      <= bss_d;
      entry_q    <= entry_d;
      tidx_q     <= tidx_d;
      addr_q     <= addr_d;
      words_q    <= words_d;
      tdone_q    <= tdone_d;
      adone_q    <= adone_d;
      err_q      <= err_d;
    end
  end

  assign credit_o    = credit;
  assign app_hash_o  = hash_q;
  assign task_cnt_o  = tcnt_q;
  assign map_we_o    = map_we_q;
  assign map_o       = map_q;
  assign ttt_o       = ttt_q;
  assign graph_we_o  = graph_we_q;
  assign graph_o     = graph_q;
  assign mem_we_o    = ((state_q == S_BINARY) & rx_i) |
                       ((state_q == S_BSS_CLR) & mem_ready_i);
  assign mem_task_o  = tidx_q;
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = (state_q == S_BINARY) ? flit : 32'd0;
  assign entry_o     = entry_q;
  assign task_done_o = tdone_q;
  assign app_done_o  = adone_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_task_stream_rx.sv
// Directed bench for task_stream_rx: parses hand-built streams and checks strobes and writes.
module tb_task_stream_rx;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        rx_i = 1'b0;
  logic [31:0] data_i = '0;
  logic        mem_ready_i = 1'b1;
  logic        credit_o;
  logic [31:0] app_hash_o;
  logic [15:0] task_cnt_o;
  logic        map_we_o;
  logic [31:0] map_o;
  logic [31:0] ttt_o;
  logic        graph_we_o;
  logic [31:0] graph_o;
  logic        mem_we_o;
  logic [15:0] mem_task_o;
  logic [15:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [31:0] entry_o;
  logic        task_done_o;
  logic        app_done_o;
  logic        err_o;

  int tests = 0;
  int fails = 0;

  task_stream_rx dut (
    .clk_i(clk), .rst_ni(rst_ni), .rx_i(rx_i), .data_i(data_i),
    .mem_ready_i(mem_ready_i), .credit_o(credit_o),
    .app_hash_o(app_hash_o), .task_cnt_o(task_cnt_o),
    .map_we_o(map_we_o), .map_o(map_o), .ttt_o(ttt_o),
    .graph_we_o(graph_we_o), .graph_o(graph_o),
    .mem_we_o(mem_we_o), .mem_task_o(mem_task_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .entry_o(entry_o), .task_done_o(task_done_o),
    .app_done_o(app_done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_map = 0, n_graph = 0, n_td = 0, n_ad = 0;
  int          n_clow = 0, n_ovl = 0, t_td = 0, t_ad = 0;
  int          n_wr = 0;
  int          wr_addr [512];
  logic [31:0] wr_data [512];
  int          wr_task [512];

  // Inputs change just after posedge, so negedge sees what the next edge acts on
  always @(negedge clk) begin
    cyc++;
    if (rst_ni) begin
      if (map_we_o) n_map++;
      if (graph_we_o) n_graph++;
      if (task_done_o) begin n_td++; t_td = cyc; end
      if (app_done_o) begin n_ad++; t_ad = cyc; end
      if (!credit_o) n_clow++;
      if ((int'(map_we_o) + int'(graph_we_o) +
           int'(task_done_o) + int'(app_done_o)) > 1) n_ovl++;
      if (mem_we_o && mem_ready_i && n_wr < 512) begin
        wr_addr[n_wr] = int'(mem_addr_o);
        wr_data[n_wr] = mem_data_o;
        wr_task[n_wr] = int'(mem_task_o);
        n_wr++;
      end
    end
  end

  int b_map, b_graph, b_td, b_ad, b_clow, b_ovl, b_wr;
  logic [31:0] strm [$];

  task automatic snap();
    b_map = n_map; b_graph = n_graph; b_td = n_td; b_ad = n_ad;
    b_clow = n_clow; b_ovl = n_ovl; b_wr = n_wr;
  endtask

  task automatic send(input logic [31:0] w);
    int n = 0;
    rx_i = 1'b1;
    data_i = w;
    @(negedge clk);
    while (!credit_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!credit_o) begin
      tests++; fails++;
      $display("FAIL send_timeout got credit=%b want 1", credit_o);
    end
    @(posedge clk);
    #1;
    rx_i = 1'b0;
  endtask

  task automatic send_n(input int first, input int last);
    for (int i = first; i <= last; i++) send(strm[i]);
  endtask

  task automatic do_reset();
    #1;
    rst_ni = 1'b0;
    rx_i = 1'b0;
    mem_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic base_stream();
    strm = '{32'd2, 32'hd5dcc234, 32'd1, 32'h0101, 32'hFFFFFFFF,
             32'd5, 32'd7, 32'd8, 32'd4, 32'd0, 32'h40,
             32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003};
  endtask

  task automatic chk_writes3();
    tests++;
    if (n_wr - b_wr !== 3) begin
      fails++;
      $display("FAIL wr_count got %0d want 3", n_wr - b_wr);
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (wr_addr[b_wr+i] !== i || wr_data[b_wr+i] !== strm[11+i]) begin
          fails++;
          $display("FAIL wr%0d got %0d:%h want %0d:%h", i,
                   wr_addr[b_wr+i], wr_data[b_wr+i], i, strm[11+i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests++;
    if (credit_o !== 1'b1 || err_o !== 1'b0 || mem_we_o !== 1'b0 ||
        task_cnt_o !== 16'd0 || mem_task_o !== 16'd0 ||
        app_hash_o !== 32'd0 || mem_addr_o !== 16'd0 ||
        map_we_o !== 1'b0 || task_done_o !== 1'b0) begin
      fails++;
      $display("FAIL reset got cr=%b err=%b we=%b tc=%0d mt=%0d want cr=1 rest 0",
               credit_o, err_o, mem_we_o, task_cnt_o, mem_task_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    base_stream();
    snap();
    send_n(0, 13);
    idle(4);
    chk_writes3();
    tests++;
    if (n_map - b_map !== 1 || n_graph - b_graph !== 2) begin
      fails++;
      $display("FAIL basic_strobes got map=%0d graph=%0d want 1 2",
               n_map - b_map, n_graph - b_graph);
    end
    tests++;
    if (n_td - b_td !== 1 || n_ad - b_ad !== 1 || t_td >= t_ad) begin
      fails++;
      $display("FAIL basic_done got td=%0d ad=%0d tt=%0d ta=%0d want 1 1 td<ad",
               n_td - b_td, n_ad - b_ad, t_td, t_ad);
    end
    tests++;
    if (app_hash_o !== 32'hd5dcc234 || task_cnt_o !== 16'd1 ||
        entry_o !== 32'h40) begin
      fails++;
      $display("FAIL basic_regs got h=%h t=%0d e=%h want d5dcc234 1 40",
               app_hash_o, task_cnt_o, entry_o);
    end
    tests++;
    if (map_o !== 32'h0101 || ttt_o !== 32'hFFFFFFFF || graph_o !== 32'd7) begin
      fails++;
      $display("FAIL basic_map got m=%h t=%h g=%0d want 101 ffffffff 7",
               map_o, ttt_o, graph_o);
    end
    tests++;
    if (n_clow - b_clow !== 2 || mem_task_o !== 16'd0 || err_o !== 1'b0) begin
      fails++;
      $display("FAIL basic_end got clow=%0d mt=%0d err=%b want 2 0 0",
               n_clow - b_clow, mem_task_o, err_o);
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    base_stream();
    snap();
    send_n(0, 11);
    mem_ready_i = 1'b0;
    rx_i = 1'b1;
    data_i = strm[12];
    repeat (3) begin
      @(negedge clk);
      if (credit_o !== 1'b0) bad++;
    end
    @(posedge clk);
    #1;
    mem_ready_i = 1'b1;
    send_n(12, 13);
    idle(4);
    tests++;
    if (bad != 0 || n_clow - b_clow !== 5) begin
      fails++;
      $display("FAIL stall_credit got bad=%0d clow=%0d want 0 5",
               bad, n_clow - b_clow);
    end
    chk_writes3();
    tests++;
    if (n_td - b_td !== 1 || n_ad - b_ad !== 1 || n_ovl - b_ovl !== 0) begin
      fails++;
      $display("FAIL stall_done got td=%0d ad=%0d ovl=%0d want 1 1 0",
               n_td - b_td, n_ad - b_ad, n_ovl - b_ovl);
    end
  endtask

  task automatic test_two_tasks();
    strm = '{32'd0, 32'h1234, 32'd2, 32'h11, 32'h22, 32'h33, 32'h44,
             32'd4, 32'd0, 32'd0, 32'h100, 32'hDEAD0000,
             32'd0, 32'd8, 32'd0, 32'h200, 32'hBEEF0001, 32'hBEEF0002};
    snap();
    send_n(0, 17);
    idle(5);
    tests++;
    if (n_wr - b_wr !== 3 ||
        wr_addr[b_wr] !== 0 || wr_task[b_wr] !== 0 ||
        wr_data[b_wr] !== 32'hDEAD0000 ||
        wr_addr[b_wr+1] !== 0 || wr_task[b_wr+1] !== 1 ||
        wr_addr[b_wr+2] !== 1 || wr_task[b_wr+2] !== 1 ||
        wr_data[b_wr+2] !== 32'hBEEF0002) begin
      fails++;
      $display("FAIL two_writes got n=%0d a1=%0d t1=%0d a2=%0d want 3 0 1 1",
               n_wr - b_wr, wr_addr[b_wr+1], wr_task[b_wr+1], wr_addr[b_wr+2]);
    end
    tests++;
    if (n_map - b_map !== 2 || n_graph - b_graph !== 0 ||
        n_td - b_td !== 2 || n_ad - b_ad !== 1) begin
      fails++;
      $display("FAIL two_strobes got m=%0d g=%0d td=%0d ad=%0d want 2 0 2 1",
               n_map - b_map, n_graph - b_graph, n_td - b_td, n_ad - b_ad);
    end
    tests++;
    if (mem_task_o !== 16'd0 || entry_o !== 32'h200 || task_cnt_o !== 16'd2) begin
      fails++;
      $display("FAIL two_regs got mt=%0d e=%h tc=%0d want 0 200 2",
               mem_task_o, entry_o, task_cnt_o);
    end
  endtask

  task automatic test_zero_tasks();
    snap();
    send(32'd1);
    send(32'h5);
    send(32'd0);
    @(negedge clk);
    tests++;
    if (err_o !== 1'b1 || credit_o !== 1'b1) begin
      fails++;
      $display("FAIL t0_err got err=%b cr=%b want 1 1", err_o, credit_o);
    end
    for (int i = 0; i < 6; i++) send(32'd1 + 32'(i));
    idle(3);
    tests++;
    if (err_o !== 1'b1 || n_clow - b_clow !== 0 || n_wr - b_wr !== 0 ||
        (n_map + n_graph + n_td + n_ad) !== (b_map + b_graph + b_td + b_ad)) begin
      fails++;
      $display("FAIL t0_hold got err=%b clow=%0d wr=%0d want 1 0 0",
               err_o, n_clow - b_clow, n_wr - b_wr);
    end
    do_reset();
    @(negedge clk);
    tests++;
    if (err_o !== 1'b0) begin
      fails++;
      $display("FAIL t0_clear got err=%b want 0", err_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_task_limit();
    send(32'd0);
    send(32'h9);
    send(32'd17);
    @(negedge clk);
    tests++;
    if (err_o !== 1'b1) begin
      fails++;
      $display("FAIL t17 got err=%b want 1", err_o);
    end
    do_reset();
    send(32'd0);
    send(32'h9);
    send(32'd16);
    @(negedge clk);
    tests++;
    if (err_o !== 1'b0 || task_cnt_o !== 16'd16) begin
      fails++;
      $display("FAIL t16 got err=%b tc=%0d want 0 16", err_o, task_cnt_o);
    end
    do_reset();
  endtask

  task automatic test_bad_size();
    snap();
    strm = '{32'd0, 32'h77, 32'd1, 32'h5, 32'h6,
             32'd6, 32'd0, 32'd0, 32'h80, 32'h1, 32'h2};
    send_n(0, 8);
    @(negedge clk);
    tests++;
    if (err_o !== 1'b1 || entry_o !== 32'h80) begin
      fails++;
      $display("FAIL size6 got err=%b e=%h want 1 80", err_o, entry_o);
    end
    send_n(9, 10);
    idle(3);
    tests++;
    if (n_wr - b_wr !== 0 || n_td - b_td !== 0) begin
      fails++;
      $display("FAIL size6_wr got wr=%0d td=%0d want 0 0",
               n_wr - b_wr, n_td - b_td);
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    base_stream();
    send_n(0, 12);
    #2;
    rst_ni = 1'b0;
    #3;
    rst_ni = 1'b1;
    @(negedge clk);
    tests++;
    if (mem_task_o !== 16'd0 || err_o !== 1'b0 || mem_we_o !== 1'b0 ||
        credit_o !== 1'b1 || app_hash_o !== 32'd0) begin
      fails++;
      $display("FAIL midrst got mt=%0d err=%b we=%b cr=%b want 0 0 0 1",
               mem_task_o, err_o, mem_we_o, credit_o);
    end
    @(posedge clk);
    #1;
    snap();
    send_n(0, 13);
    idle(4);
    chk_writes3();
    tests++;
    if (n_td - b_td !== 1 || n_ad - b_ad !== 1 || err_o !== 1'b0 ||
        mem_task_o !== 16'd0 || app_hash_o !== 32'hd5dcc234) begin
      fails++;
      $display("FAIL midrst_parse got td=%0d ad=%0d err=%b want 1 1 0",
               n_td - b_td, n_ad - b_ad, err_o);
    end
  endtask

`ifdef TASK_RX_BSS_CLEAR_EN
  task automatic test_bss_clear();
    base_stream();
    strm[9] = 32'd8;
    snap();
    send_n(0, 13);
    idle(6);
    tests++;
    if (n_wr - b_wr !== 5 || wr_addr[b_wr+3] !== 3 || wr_data[b_wr+3] !== 32'd0 ||
        wr_addr[b_wr+4] !== 4 || wr_data[b_wr+4] !== 32'd0) begin
      fails++;
      $display("FAIL bss got n=%0d a3=%0d a4=%0d want 5 3 4",
               n_wr - b_wr, wr_addr[b_wr+3], wr_addr[b_wr+4]);
    end
    tests++;
    if (n_clow - b_clow !== 4 || n_td - b_td !== 1 || n_ad - b_ad !== 1) begin
      fails++;
      $display("FAIL bss_flow got clow=%0d td=%0d want 4 1",
               n_clow - b_clow, n_td - b_td);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_two_tasks();
    test_zero_tasks();
    test_task_limit();
    test_bad_size();
    test_reset_mid();
`ifdef TASK_RX_BSS_CLEAR_EN
    test_bss_clear();
`endif
    tests++;
    if (n_ovl !== 0) begin
      fails++;
      $display("FAIL strobe_overlap got %0d want 0", n_ovl);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
